wr_status_sync: RTL and testbench

Write-clock-domain companion to the dcfifo write pointer/full stage. It synchronizes the read pointer's Gray code into `clk_wr` and hands the result to the write pointer stage for full detection. From the write pointer's Gray code and the synchronized read pointer it derives a registered fill level, an almost-full flag and a sticky overflow error flag. It is instantiated once per dcfifo, entirely in the `clk_wr` domain.

---
 rtl/wr_status_sync_if.sv | 24 ++
 rtl/wr_status_sync.sv | 73 +++++++
 tb/tb_wr_status_sync.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/wr_status_sync_if.sv
// rtl/wr_status_sync_if.sv - write-domain status bus for the dcfifo read-pointer sync / fill-level block
interface wr_status_sync_if #(
  parameter int PTR_WITH = 4
);
  logic [PTR_WITH:0] rd_gray;
  logic [PTR_WITH:0] wr_gray;
  logic              wr_en;
  logic              wr_full;
  logic              ovf_clr;
  logic [PTR_WITH:0] rd_gray_sync_wr;
  logic [PTR_WITH:0] wr_usedw;
  logic              wr_almost_full;
  logic              wr_overflow;

  modport master (
    output rd_gray, wr_gray, wr_en, wr_full, ovf_clr,
    input  rd_gray_sync_wr, wr_usedw, wr_almost_full, wr_overflow
  );

  modport slave (
    input  rd_gray, wr_gray, wr_en, wr_full, ovf_clr,
    output rd_gray_sync_wr, wr_usedw, wr_almost_full, wr_overflow
  );
endinterface

// File: rtl/wr_status_sync.sv
// rtl/wr_status_sync.sv - read-pointer synchronizer, fill level, almost-full and sticky overflow in clk_wr
module wr_status_sync #(
  parameter int PTR_WITH    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_TH    = 12
) (
  input  logic              clk_wr,
  input  logic              rst_wr,
  wr_status_sync_if.slave   bus
);

  localparam logic [PTR_WITH:0] AFULL_LVL = (PTR_WITH + 1)'(AFULL_TH);

  logic [SYNC_STAGES-1:0][PTR_WITH:0] sync_q, sync_d;
  logic [PTR_WITH:0]                  usedw_q, usedw_d;
  logic                               afull_q, afull_d;
  logic                               ovf_q, ovf_d;

  logic [PTR_WITH:0] rd_bin;
  logic [PTR_WITH:0] wr_bin;

  function automatic logic [PTR_WITH:0] gray2bin(input logic [PTR_WITH:0] g);
    logic [PTR_WITH:0] b;
    b[PTR_WITH] = g[PTR_WITH];
    for (int i = PTR_WITH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Plain shift chain: stage 0 is the only flop that may go metastable.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.rd_gray};
  end

  // The stale read pointer can only make the level look higher, never lower.
  always_comb begin
    rd_bin  = gray2bin(sync_q[SYNC_STAGES-1]);
    wr_bin  = gray2bin(bus.wr_gray);
    usedw_d = wr_bin - rd_bin;
    afull_d = (usedw_d >= AFULL_LVL);
  end

  // Set has priority over clear so a write while full is never lost.
  always_comb begin
    ovf_d = ovf_q;
    if (bus.wr_en && bus.wr_full) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      sync_q  <= '0;
      usedw_q <= '0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      usedw_q <= usedw_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.rd_gray_sync_wr = sync_q[SYNC_STAGES-1];
  assign bus.wr_usedw        = usedw_q;
  assign bus.wr_almost_full  = afull_q;
  assign bus.wr_overflow     = ovf_q;

endmodule

// File: tb/tb_wr_status_sync.sv
// tb/tb_wr_status_sync.sv - directed self-checking bench for wr_status_sync
module tb_wr_status_sync;

  logic clk_wr = 1'b0;
  logic rst_wr = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  wr_status_sync_if #(.PTR_WITH(4)) bus ();

  wr_status_sync #(
    .PTR_WITH   (4),
    .SYNC_STAGES(2),
    .AFULL_TH   (12)
  ) dut (
    .clk_wr(clk_wr),
    .rst_wr(rst_wr),
    .bus   (bus)
  );

  always #5 clk_wr = ~clk_wr;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_wr);
    #1;
  endtask

  task automatic test_reset;
    rst_wr = 1'b1;
    bus.rd_gray = 5'b00011; bus.wr_gray = 5'b0;
    bus.wr_en = 1'b0; bus.wr_full = 1'b0; bus.ovf_clr = 1'b0;
    tick(2);
    n_cmp++; if (bus.rd_gray_sync_wr !== 5'd0) begin $display("FAIL rst_sync got %0d exp 0", bus.rd_gray_sync_wr); n_fail++; end
    n_cmp++; if (bus.wr_usedw !== 5'd0) begin $display("FAIL rst_usedw got %0d exp 0", bus.wr_usedw); n_fail++; end
    n_cmp++; if (bus.wr_almost_full !== 1'b0) begin $display("FAIL rst_afull got %0b exp 0", bus.wr_almost_full); n_fail++; end
    n_cmp++; if (bus.wr_overflow !== 1'b0) begin $display("FAIL rst_ovf got %0b exp 0", bus.wr_overflow); n_fail++; end
    rst_wr = 1'b0;
    tick(2);
    n_cmp++; if (bus.rd_gray_sync_wr !== 5'b00011) begin $display("FAIL rst_sync2 got %b exp 00011", bus.rd_gray_sync_wr); n_fail++; end
    n_cmp++; if (bus.wr_usedw !== 5'd0) begin $display("FAIL rst_usedw2 got %0d exp 0", bus.wr_usedw); n_fail++; end
    tick(1);
    n_cmp++; if (bus.wr_usedw !== 5'd30) begin $display("FAIL rst_usedw3 got %0d exp 30", bus.wr_usedw); n_fail++; end
    n_cmp++; if (bus.wr_almost_full !== 1'b1) begin $display("FAIL rst_afull3 got %0b exp 1", bus.wr_almost_full); n_fail++; end
  endtask

  task automatic test_writes;
    logic [4:0] g_tab [3];
    logic [4:0] u_tab [3];
    g_tab = '{5'b00001, 5'b00011, 5'b00010};
    u_tab = '{5'd1, 5'd2, 5'd3};
    bus.rd_gray = 5'b0;
    tick(3);
    n_cmp++; if (bus.wr_usedw !== 5'd0) begin $display("FAIL wr_base got %0d exp 0", bus.wr_usedw); n_fail++; end
    for (int i = 0; i < 3; i++) begin
      bus.wr_gray = g_tab[i];
      tick(1);
      n_cmp++; if (bus.wr_usedw !== u_tab[i]) begin $display("FAIL wr_usedw[%0d] got %0d exp %0d", i, bus.wr_usedw, u_tab[i]); n_fail++; end
      n_cmp++; if (bus.wr_almost_full !== 1'b0) begin $display("FAIL wr_afull[%0d] got %0b exp 0", i, bus.wr_almost_full); n_fail++; end
    end
  endtask

  task automatic test_almost_full;
    bus.wr_gray = 5'b01010;
    tick(1);
    n_cmp++; if (bus.wr_usedw !== 5'd12) begin $display("FAIL af_usedw got %0d exp 12", bus.wr_usedw); n_fail++; end
    n_cmp++; if (bus.wr_almost_full !== 1'b1) begin $display("FAIL af_set got %0b exp 1", bus.wr_almost_full); n_fail++; end
    bus.rd_gray = 5'b00001;
    tick(2);
    n_cmp++; if (bus.wr_usedw !== 5'd12) begin $display("FAIL af_lat_usedw got %0d exp 12", bus.wr_usedw); n_fail++; end
    tick(1);
    n_cmp++; if (bus.wr_usedw !== 5'd11) begin $display("FAIL af_usedw11 got %0d exp 11", bus.wr_usedw); n_fail++; end
    n_cmp++; if (bus.wr_almost_full !== 1'b0) begin $display("FAIL af_clr got %0b exp 0", bus.wr_almost_full); n_fail++; end
  endtask

  task automatic test_wrap;
    bus.wr_gray = 5'b00011;
    bus.rd_gray = 5'b10001;
    tick(2);
    n_cmp++; if (bus.rd_gray_sync_wr !== 5'b10001) begin $display("FAIL wrap_sync got %b exp 10001", bus.rd_gray_sync_wr); n_fail++; end
    tick(1);
    n_cmp++; if (bus.wr_usedw !== 5'd4) begin $display("FAIL wrap_usedw got %0d exp 4", bus.wr_usedw); n_fail++; end
    n_cmp++; if (bus.wr_almost_full !== 1'b0) begin $display("FAIL wrap_afull got %0b exp 0", bus.wr_almost_full); n_fail++; end
  endtask

  task automatic test_overflow;
    bus.wr_gray = 5'b11000;
    bus.rd_gray = 5'b0;
    tick(3);
    n_cmp++; if (bus.wr_usedw !== 5'd16) begin $display("FAIL full_usedw got %0d exp 16", bus.wr_usedw); n_fail++; end
    n_cmp++; if (bus.wr_almost_full !== 1'b1) begin $display("FAIL full_afull got %0b exp 1", bus.wr_almost_full); n_fail++; end
    n_cmp++; if (bus.wr_overflow !== 1'b0) begin $display("FAIL ovf_idle got %0b exp 0", bus.wr_overflow); n_fail++; end
    bus.wr_en = 1'b1; bus.wr_full = 1'b1;
    tick(1);
    bus.wr_en = 1'b0; bus.wr_full = 1'b0;
    n_cmp++; if (bus.wr_overflow !== 1'b1) begin $display("FAIL ovf_set got %0b exp 1", bus.wr_overflow); n_fail++; end
    tick(1);
    n_cmp++; if (bus.wr_overflow !== 1'b1) begin $display("FAIL ovf_hold got %0b exp 1", bus.wr_overflow); n_fail++; end
    bus.ovf_clr = 1'b1; bus.wr_en = 1'b1; bus.wr_full = 1'b1;
    tick(1);
    bus.wr_en = 1'b0; bus.wr_full = 1'b0;
    n_cmp++; if (bus.wr_overflow !== 1'b1) begin $display("FAIL ovf_set_wins got %0b exp 1", bus.wr_overflow); n_fail++; end
    tick(1);
    bus.ovf_clr = 1'b0;
    n_cmp++; if (bus.wr_overflow !== 1'b0) begin $display("FAIL ovf_clr got %0b exp 0", bus.wr_overflow); n_fail++; end
    bus.wr_en = 1'b1;
    tick(1);
    bus.wr_en = 1'b0;
    n_cmp++; if (bus.wr_overflow !== 1'b0) begin $display("FAIL ovf_en_only got %0b exp 0", bus.wr_overflow); n_fail++; end
  endtask

  task automatic test_mid_reset;
    bus.wr_en = 1'b1; bus.wr_full = 1'b1;
    tick(1);
    bus.wr_en = 1'b0; bus.wr_full = 1'b0;
    n_cmp++; if (bus.wr_overflow !== 1'b1) begin $display("FAIL mr_pre_ovf got %0b exp 1", bus.wr_overflow); n_fail++; end
    n_cmp++; if (bus.wr_usedw !== 5'd16) begin $display("FAIL mr_pre_usedw got %0d exp 16", bus.wr_usedw); n_fail++; end
    #2 rst_wr = 1'b1;
    #1;
    n_cmp++; if (bus.wr_usedw !== 5'd0) begin $display("FAIL mr_usedw got %0d exp 0", bus.wr_usedw); n_fail++; end
    n_cmp++; if (bus.wr_almost_full !== 1'b0) begin $display("FAIL mr_afull got %0b exp 0", bus.wr_almost_full); n_fail++; end
    n_cmp++; if (bus.wr_overflow !== 1'b0) begin $display("FAIL mr_ovf got %0b exp 0", bus.wr_overflow); n_fail++; end
    n_cmp++; if (bus.rd_gray_sync_wr !== 5'd0) begin $display("FAIL mr_sync got %0d exp 0", bus.rd_gray_sync_wr); n_fail++; end
    #2 rst_wr = 1'b0;
    tick(1);
    n_cmp++; if (bus.wr_usedw !== 5'd16) begin $display("FAIL mr_restart_usedw got %0d exp 16", bus.wr_usedw); n_fail++; end
    n_cmp++; if (bus.wr_overflow !== 1'b0) begin $display("FAIL mr_restart_ovf got %0b exp 0", bus.wr_overflow); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_writes();
    test_almost_full();
    test_wrap();
    test_overflow();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
